// File: rtl/bl_table_loader.sv
// rtl/bl_table_loader.sv - unpacks 32 packed length words into even/odd bit-length table writes
// Optional Kraft check (kraft_ok port) enabled by defining BLT_LOADER_KRAFT_EN.
`timescale 1ns/1ps
module bl_table_loader (
   input  logic        clk,
   input  logic        rstN,
   input  logic        load_start,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [6:0]  blt_even_waddr,
   output logic        blt_even_wr,
   output logic [3:0]  blt_even_wdata,
   output logic [6:0]  blt_odd_waddr,
   output logic        blt_odd_wr,
   output logic [3:0]  blt_odd_wdata,
   output logic        load_busy,
   output logic        load_done,
   output logic [8:0]  sym_nz_count,
`ifdef BLT_LOADER_KRAFT_EN
   output logic        kraft_ok,
`endif
   output logic [3:0]  max_len
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_DONE = 2'd2} state_t;

   state_t      state, state_nx;
   logic [31:0] word_buf, buf_nx;
   logic        buf_valid, bv_nx;
   logic [1:0]  beat, beat_nx;
   logic [4:0]  word_idx, word_nx;
   logic [5:0]  words_acc, acc_nx;
   logic [8:0]  nz_nx;
   logic [3:0]  max_nx;
   logic [31:0] shifted, shifted_nx;
   logic [3:0]  nib_e, nib_o;
   logic        accept, writing;

   assign in_ready = (state == S_LOAD) && (words_acc < 6'd32) &&
                     (!buf_valid || beat == 2'd3) && !load_start;
   assign accept   = in_valid & in_ready;
   // A load_start cycle never writes, even if the buffer still holds a word.
   assign writing  = buf_valid & ~load_start;

   assign shifted    = word_buf << {beat, 3'b000};
   assign nib_e      = shifted[31:28];
   assign nib_o      = shifted[27:24];
   assign shifted_nx = buf_nx << {beat_nx, 3'b000};

   assign blt_even_wr = writing;
   assign blt_odd_wr  = writing;

   always_comb begin
      state_nx = state;
      buf_nx   = word_buf;
      bv_nx    = buf_valid;
      beat_nx  = beat;
      word_nx  = word_idx;
      acc_nx   = words_acc;
      nz_nx    = sym_nz_count;
      max_nx   = max_len;
      if (load_start) begin
         state_nx = S_LOAD;
         bv_nx    = 1'b0;
         beat_nx  = 2'd0;
         word_nx  = 5'd0;
         acc_nx   = 6'd0;
         nz_nx    = 9'd0;
         max_nx   = 4'd0;
      end else begin
         if (writing) begin
            beat_nx = beat + 2'd1;
            nz_nx   = sym_nz_count + {8'd0, |nib_e} + {8'd0, |nib_o};
            if (nib_e > max_nx) max_nx = nib_e;
            if (nib_o > max_nx) max_nx = nib_o;
            if (beat == 2'd3) begin
               word_nx = word_idx + 5'd1;
               bv_nx   = 1'b0;
            end
         end
         if (accept) begin
            buf_nx = in_data;
            bv_nx  = 1'b1;
            acc_nx = words_acc + 6'd1;
         end
         case (state)
            S_IDLE:  state_nx = S_IDLE;
            S_LOAD:  if (acc_nx == 6'd32 && !bv_nx) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state          <= S_IDLE;
         word_buf       <= 32'd0;
         buf_valid      <= 1'b0;
         beat           <= 2'd0;
         word_idx       <= 5'd0;
         words_acc      <= 6'd0;
         sym_nz_count   <= 9'd0;
         max_len        <= 4'd0;
         load_busy      <= 1'b0;
         load_done      <= 1'b0;
         blt_even_waddr <= 7'd0;
         blt_even_wdata <= 4'd0;
         blt_odd_waddr  <= 7'd0;
         blt_odd_wdata  <= 4'd0;
      end else begin
         state        <= state_nx;
         word_buf     <= buf_nx;
         buf_valid    <= bv_nx;
         beat         <= beat_nx;
         word_idx     <= word_nx;
         words_acc    <= acc_nx;
         sym_nz_count <= nz_nx;
         max_len      <= max_nx;
         load_busy    <= (state_nx == S_LOAD);
         load_done    <= (state_nx == S_DONE);
         // Address/data present the pair that will be written in the coming cycle.
         if (bv_nx) begin
            blt_even_waddr <= {word_nx, beat_nx};
            blt_even_wdata <= shifted_nx[31:28];
            blt_odd_waddr  <= {word_nx, beat_nx};
            blt_odd_wdata  <= shifted_nx[27:24];
         end
      end
   end

`ifdef BLT_LOADER_KRAFT_EN
   logic [22:0] ksum, ksum_nx;

   function automatic logic [22:0] kterm(input logic [3:0] len);
      kterm = (len == 4'd0) ? 23'd0 : (23'd1 << (4'd15 - len));
   endfunction

   always_comb begin
      ksum_nx = ksum;
      if (load_start)   ksum_nx = 23'd0;
      else if (writing) ksum_nx = ksum + kterm(nib_e) + kterm(nib_o);
   end

   // A lone symbol of length 1 sums to 2^14 but is still a valid code.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         ksum     <= 23'd0;
         kraft_ok <= 1'b0;
      end else begin
         ksum <= ksum_nx;
         if (load_start)
            kraft_ok <= 1'b0;
         else if (state == S_LOAD && state_nx == S_DONE)
            kraft_ok <= (ksum_nx == 23'h8000) || (nz_nx == 9'd1 && ksum_nx == 23'h4000);
      end
   end
`endif

endmodule

// File: tb/tb_bl_table_loader.sv
// tb/tb_bl_table_loader.sv - randomized self-checking bench for bl_table_loader
`timescale 1ns/1ps
module tb_bl_table_loader;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic        load_start = 1'b0;
   logic [31:0] in_data = 32'd0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [6:0]  blt_even_waddr, blt_odd_waddr;
   logic        blt_even_wr, blt_odd_wr;
   logic [3:0]  blt_even_wdata, blt_odd_wdata;
   logic        load_busy, load_done;
   logic [8:0]  sym_nz_count;
   logic [3:0]  max_len;
`ifdef BLT_LOADER_KRAFT_EN
   logic        kraft_ok;
`endif

   bl_table_loader dut (
      .clk(clk), .rstN(rstN), .load_start(load_start),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .blt_even_waddr(blt_even_waddr), .blt_even_wr(blt_even_wr), .blt_even_wdata(blt_even_wdata),
      .blt_odd_waddr(blt_odd_waddr), .blt_odd_wr(blt_odd_wr), .blt_odd_wdata(blt_odd_wdata),
      .load_busy(load_busy), .load_done(load_done), .sym_nz_count(sym_nz_count),
`ifdef BLT_LOADER_KRAFT_EN
      .kraft_ok(kraft_ok),
`endif
      .max_len(max_len)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   logic [31:0] wq [32];
   logic [3:0]  tbl_e [128];
   logic [3:0]  tbl_o [128];
   int          cnt_e [128];
   int          cnt_o [128];
   int          n_writes, bad_pairs, wr_in_start, first_addr;
   int          abort_addr, abort_wr;

   logic [3:0]  exp_e [128];
   logic [3:0]  exp_o [128];
   int          exp_nz, exp_max;
   bit          exp_kok;

   // Table-side observer: what a RAM on the two write ports would capture.
   always @(negedge clk) begin
      if (blt_even_wr !== blt_odd_wr || (blt_even_wr && blt_even_waddr !== blt_odd_waddr))
         bad_pairs++;
      if (load_start && (blt_even_wr || blt_odd_wr))
         wr_in_start++;
      if (blt_even_wr === 1'b1) begin
         if (n_writes == 0) first_addr = int'(blt_even_waddr);
         tbl_e[blt_even_waddr] = blt_even_wdata;
         cnt_e[blt_even_waddr]++;
         n_writes++;
      end
      if (blt_odd_wr === 1'b1) begin
         tbl_o[blt_odd_waddr] = blt_odd_wdata;
         cnt_o[blt_odd_waddr]++;
      end
   end

   task automatic clear_mon();
      for (int k = 0; k < 128; k++) begin
         cnt_e[k] = 0;
         cnt_o[k] = 0;
      end
      n_writes = 0;
      bad_pairs = 0;
      first_addr = -1;
   endtask

   // Symbol s lives in word s/8, nibble s%8 counted from the top.
   task automatic build_model();
      int ksum, last_nz;
      logic [31:0] wv;
      logic [3:0]  len;
      exp_nz = 0; exp_max = 0; ksum = 0; last_nz = 0;
      for (int s = 0; s < 256; s++) begin
         wv = wq[s / 8];
         len = wv[31 - 4 * (s % 8) -: 4];
         if (s % 2 == 0) exp_e[s / 2] = len;
         else            exp_o[s / 2] = len;
         if (len != 0) begin
            exp_nz++;
            ksum += 1 << (15 - int'(len));
            last_nz = int'(len);
         end
         if (int'(len) > exp_max) exp_max = int'(len);
      end
      exp_kok = (ksum == 32768) || (exp_nz == 1 && last_nz == 1);
   endtask

   function automatic int content_errs();
      int e = 0;
      for (int k = 0; k < 128; k++)
         if (tbl_e[k] !== exp_e[k] || tbl_o[k] !== exp_o[k]) e++;
      return e;
   endfunction

   function automatic int count_errs();
      int e = 0;
      for (int k = 0; k < 128; k++)
         if (cnt_e[k] != 1 || cnt_o[k] != 1) e++;
      return e;
   endfunction

   function automatic int readback_errs();
      int e = 0;
      logic [31:0] rb;
      for (int w = 0; w < 32; w++) begin
         rb = {tbl_e[4*w], tbl_o[4*w], tbl_e[4*w+1], tbl_o[4*w+1],
               tbl_e[4*w+2], tbl_o[4*w+2], tbl_e[4*w+3], tbl_o[4*w+3]};
         if (rb !== wq[w]) e++;
      end
      return e;
   endfunction

   // Runs one load; after the 32nd word an extra word stays offered to probe in_ready.
   task automatic do_load(input int gap_pct, input int abort_cyc, output int done_at, output int n_acc);
      int t0, i;
      bit aborted;
      i = 0; done_at = -1; aborted = 0;
      clear_mon();
      in_valid = 1'b0;
      load_start = 1'b1;
      t0 = cyc;
      @(posedge clk); #1;
      load_start = 1'b0;
      while (done_at < 0 && cyc - t0 < 1200) begin
         if (i < 32) begin
            in_data  = wq[i];
            in_valid = ($urandom_range(0, 99) >= gap_pct);
         end else begin
            in_data  = 32'hDEADBEEF;
            in_valid = 1'b1;
         end
         if (!aborted && abort_cyc > 0 && cyc - t0 == abort_cyc) load_start = 1'b1;
         @(negedge clk);
         if (load_start) begin
            abort_addr = int'(blt_even_waddr);
            abort_wr   = int'(blt_even_wr | blt_odd_wr);
            clear_mon();
            i = 0; aborted = 1; t0 = cyc;
         end else begin
            if (in_valid && in_ready) i++;
            if (load_done) done_at = cyc - t0;
         end
         @(posedge clk); #1;
         load_start = 1'b0;
      end
      n_acc = i;
   endtask

   task automatic test_reset();
      int t0, done_at, n_acc;
      @(negedge clk); @(negedge clk);
      checks++; if (in_ready !== 1'b0 || load_busy !== 1'b0 || load_done !== 1'b0) begin
         failures++; $display("FAIL reset_ctrl got ready=%b busy=%b done=%b exp 0 0 0", in_ready, load_busy, load_done); end
      checks++; if ({blt_even_wr, blt_odd_wr, blt_even_waddr, blt_odd_waddr, blt_even_wdata, blt_odd_wdata} !== 24'd0) begin
         failures++; $display("FAIL reset_write_ports got nonzero exp all zero"); end
      checks++; if (sym_nz_count !== 9'd0 || max_len !== 4'd0) begin
         failures++; $display("FAIL reset_stats got nz=%0d max=%0d exp 0 0", sym_nz_count, max_len); end
`ifdef BLT_LOADER_KRAFT_EN
      checks++; if (kraft_ok !== 1'b0) begin failures++; $display("FAIL reset_kraft got %b exp 0", kraft_ok); end
`endif
      @(posedge clk); #1; rstN = 1'b1;
      // Reset asserted asynchronously in the middle of a load.
      for (int w = 0; w < 32; w++) wq[w] = $urandom;
      load_start = 1'b1; t0 = cyc;
      @(posedge clk); #1; load_start = 1'b0;
      in_valid = 1'b1; in_data = wq[0];
      while (cyc - t0 < 50) begin @(posedge clk); #1; in_data = $urandom; end
      #2 rstN = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b0 || load_busy !== 1'b0 || blt_even_wr !== 1'b0 || sym_nz_count !== 9'd0) begin
         failures++; $display("FAIL reset_midload got ready=%b busy=%b wr=%b nz=%0d exp 0 0 0 0", in_ready, load_busy, blt_even_wr, sym_nz_count); end
      in_valid = 1'b0;
      @(posedge clk); @(posedge clk); #1; rstN = 1'b1;
      @(posedge clk); #1;
      build_model();
      do_load(0, 0, done_at, n_acc);
      checks++; if (done_at != 130) begin failures++; $display("FAIL post_reset_done got %0d exp 130", done_at); end
      checks++; if (content_errs() != 0) begin failures++; $display("FAIL post_reset_table got %0d bad entries exp 0", content_errs()); end
   endtask

   task automatic test_full_load();
      int done_at, n_acc;
      for (int w = 0; w < 32; w++) wq[w] = 32'h01234567 + w;
      build_model();
      do_load(0, 0, done_at, n_acc);
      checks++; if (done_at != 130) begin failures++; $display("FAIL full_done_cycle got %0d exp 130", done_at); end
      checks++; if (content_errs() != 0) begin failures++; $display("FAIL full_table got %0d bad entries exp 0", content_errs()); end
      checks++; if (readback_errs() != 0) begin failures++; $display("FAIL full_readback got %0d bad words exp 0", readback_errs()); end
      checks++; if (count_errs() != 0 || n_writes != 128) begin
         failures++; $display("FAIL full_write_count got writes=%0d bad=%0d exp 128 0", n_writes, count_errs()); end
      checks++; if (int'(sym_nz_count) != exp_nz || int'(max_len) != exp_max) begin
         failures++; $display("FAIL full_stats got nz=%0d max=%0d exp %0d %0d", sym_nz_count, max_len, exp_nz, exp_max); end
      checks++; if (n_acc != 32) begin failures++; $display("FAIL extra_word_accepted got %0d words exp 32", n_acc); end
      in_valid = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b0 || load_busy !== 1'b0 || load_done !== 1'b0) begin
         failures++; $display("FAIL back_to_idle got ready=%b busy=%b done=%b exp 0 0 0", in_ready, load_busy, load_done); end
      @(posedge clk); #1; in_valid = 1'b0;
   endtask

   task automatic test_gaps();
      int done_at, n_acc;
      for (int r = 0; r < 2; r++) begin
         for (int w = 0; w < 32; w++) wq[w] = $urandom;
         build_model();
         do_load(50, 0, done_at, n_acc);
         checks++; if (done_at < 130) begin failures++; $display("FAIL gaps_done got %0d exp >=130", done_at); end
         checks++; if (content_errs() != 0 || readback_errs() != 0) begin
            failures++; $display("FAIL gaps_table got %0d bad entries exp 0", content_errs()); end
         checks++; if (count_errs() != 0 || n_writes != 128 || bad_pairs != 0) begin
            failures++; $display("FAIL gaps_writes got writes=%0d dup_or_skip=%0d pair_err=%0d exp 128 0 0", n_writes, count_errs(), bad_pairs); end
         checks++; if (int'(sym_nz_count) != exp_nz || int'(max_len) != exp_max) begin
            failures++; $display("FAIL gaps_stats got nz=%0d max=%0d exp %0d %0d", sym_nz_count, max_len, exp_nz, exp_max); end
         in_valid = 1'b0;
      end
   endtask

   task automatic test_abort();
      int done_at, n_acc;
      for (int w = 0; w < 32; w++) wq[w] = $urandom | 32'h11111111;
      build_model();
      wr_in_start = 0;
      do_load(0, 44, done_at, n_acc);
      checks++; if (abort_wr != 0 || wr_in_start != 0) begin
         failures++; $display("FAIL abort_no_write got wr=%0d exp 0", abort_wr); end
      checks++; if (abort_addr != 42) begin failures++; $display("FAIL abort_position got addr=%0d exp 42", abort_addr); end
      checks++; if (first_addr != 0) begin failures++; $display("FAIL abort_restart_addr got %0d exp 0", first_addr); end
      checks++; if (done_at != 130 || content_errs() != 0) begin
         failures++; $display("FAIL abort_reload got done=%0d bad=%0d exp 130 0", done_at, content_errs()); end
      checks++; if (int'(sym_nz_count) != exp_nz) begin
         failures++; $display("FAIL abort_nz_count got %0d exp %0d", sym_nz_count, exp_nz); end
      in_valid = 1'b0;
   endtask

   task automatic test_flat();
      int done_at, n_acc;
      for (int w = 0; w < 32; w++) wq[w] = 32'h88888888;
      build_model();
      do_load(25, 0, done_at, n_acc);
      checks++; if (sym_nz_count !== 9'd256 || max_len !== 4'd8) begin
         failures++; $display("FAIL flat_stats got nz=%0d max=%0d exp 256 8", sym_nz_count, max_len); end
`ifdef BLT_LOADER_KRAFT_EN
      checks++; if (kraft_ok !== exp_kok) begin failures++; $display("FAIL flat_kraft got %b exp %b", kraft_ok, exp_kok); end
`endif
      in_valid = 1'b0;
      wq[$urandom_range(0, 31)] = 32'h88880888;
      build_model();
      do_load(0, 0, done_at, n_acc);
      checks++; if (int'(sym_nz_count) != exp_nz || exp_nz != 255) begin
         failures++; $display("FAIL flat_one_zero got nz=%0d exp 255", sym_nz_count); end
`ifdef BLT_LOADER_KRAFT_EN
      checks++; if (kraft_ok !== exp_kok) begin failures++; $display("FAIL flat_one_zero_kraft got %b exp %b", kraft_ok, exp_kok); end
      in_valid = 1'b0;
      for (int w = 0; w < 32; w++) wq[w] = 32'd0;
      wq[$urandom_range(0, 31)] = 32'h00100000;
      build_model();
      do_load(0, 0, done_at, n_acc);
      checks++; if (kraft_ok !== exp_kok || sym_nz_count !== 9'd1) begin
         failures++; $display("FAIL single_symbol_kraft got kraft=%b nz=%0d exp %b 1", kraft_ok, sym_nz_count, exp_kok); end
`endif
      in_valid = 1'b0;
   endtask

   initial begin
      clear_mon();
      test_reset();
      test_full_load();
      test_gaps();
      test_abort();
      test_flat();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
